// File: rtl/card_dealer.sv
// Card dealer: deals random ranks 1..13 from a finite shoe without replacement.
// A free-running rank counter is sampled when deal is requested; if that rank
// is exhausted, the search walks forward (wrapping 13 -> 1) to the next rank
// that still has cards left.
//
// state  | meaning
// IDLE   | waiting for deal_req; new_card holds the last dealt rank
// SEARCH | checking cand against the count table, one rank per cycle
module card_dealer #(
    parameter int DECKS = 1
) (
    input  logic                            clock,
    input  logic                            resetb,
    input  logic                            deal_req,
    input  logic                            refill,
    output logic [3:0]                      new_card,
    output logic                            card_valid,
    output logic [$clog2(52*DECKS+1)-1:0]   cards_left,
    output logic                            empty,
    output logic                            busy
);

    localparam int CW = $clog2(52*DECKS+1);
    localparam int NW = $clog2(4*DECKS+1);
    localparam logic [NW-1:0] FULL_CNT  = NW'(4*DECKS);
    localparam logic [CW-1:0] FULL_SHOE = CW'(52*DECKS);

    typedef enum logic {IDLE, SEARCH} state_t;

    state_t        state;
    logic [3:0]    rng;
    logic [3:0]    cand;
    logic [NW-1:0] cnt [1:13];

    // Free-running rank counter 1..13; keeps running through refill and deals.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            rng <= 4'd1;
        end else begin
            rng <= (rng == 4'd13) ? 4'd1 : rng + 4'd1;
        end
    end

    // Deal FSM, count table and registered outputs; refill overrides all of it.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state      <= IDLE;
            cand       <= 4'd1;
            new_card   <= 4'd0;
            card_valid <= 1'b0;
            cards_left <= FULL_SHOE;
            for (int i = 1; i <= 13; i++) cnt[i] <= FULL_CNT;
        end else if (refill) begin
            state      <= IDLE;
            new_card   <= 4'd0;
            card_valid <= 1'b0;
            cards_left <= FULL_SHOE;
            for (int i = 1; i <= 13; i++) cnt[i] <= FULL_CNT;
        end else begin
            card_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (deal_req && (cards_left != '0)) begin
                        cand  <= rng;
                        state <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (cnt[cand] != '0) begin
                        cnt[cand]  <= cnt[cand] - NW'(1);
                        cards_left <= cards_left - CW'(1);
                        new_card   <= cand;
                        card_valid <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        cand <= (cand == 4'd13) ? 4'd1 : cand + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status flags decoded from registered state only.
    assign busy  = (state == SEARCH);
    assign empty = (cards_left == '0);

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer (DECKS=1): table-driven deals with a
// scoreboard of expected cards, plus reset, refill and drain sequences.
module tb_card_dealer;

    logic       clock = 1'b0;
    logic       resetb = 1'b0;
    logic       deal_req = 1'b0;
    logic       refill = 1'b0;
    logic [3:0] new_card;
    logic       card_valid;
    logic [5:0] cards_left;
    logic       empty;
    logic       busy;

    int checks = 0;
    int errors = 0;

    card_dealer #(.DECKS(1)) dut (
        .clock      (clock),
        .resetb     (resetb),
        .deal_req   (deal_req),
        .refill     (refill),
        .new_card   (new_card),
        .card_valid (card_valid),
        .cards_left (cards_left),
        .empty      (empty),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // Independent model of the rank counter and an edge counter.
    int rng_m = 1;
    int cyc = 0;
    always @(posedge clock or negedge resetb) begin
        if (!resetb) rng_m <= 1;
        else rng_m <= (rng_m == 13) ? 1 : rng_m + 1;
    end
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int card;
        int left;
        int due;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int r;
        int card;
        int lat;
    } vec_t;
    vec_t vecs[15];

    logic drain_mode = 1'b0;
    int   drain_cnt = 0;
    int   rank_cnt[0:15];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Scoreboard / drain monitor on the falling edge.
    always @(negedge clock) begin
        if (resetb && card_valid) begin
            if (drain_mode) begin
                rank_cnt[new_card]++;
                drain_cnt++;
                chk("drain_left", int'(cards_left), 52 - drain_cnt);
            end else if (sbq.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("deal_card", int'(new_card), e.card);
                chk("deal_left", int'(cards_left), e.left);
                chk("deal_latency", cyc, e.due);
            end
        end
    end

    // Request one card when the modelled rng equals r; called at a negedge.
    task automatic deal_at(input int r, input int card, input int lat, input int left);
        int n;
        exp_t e;
        n = 0;
        while (rng_m != r && n < 30) begin
            @(negedge clock);
            n++;
        end
        if (rng_m != r) chk("rng_align", rng_m, r);
        deal_req = 1'b1;
        e.card = card;
        e.left = left;
        e.due  = cyc + 1 + lat;
        sbq.push_back(e);
        @(negedge clock);
        deal_req = 1'b0;
        chk("busy_after_req", int'(busy), 1);
        n = 0;
        while (sbq.size() != 0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (sbq.size() != 0) begin
            chk("deal_timeout", sbq.size(), 0);
            sbq.delete();
        end
        @(negedge clock);
        chk("card_hold", int'(new_card), card);
        chk("valid_one_cycle", int'(card_valid), 0);
        chk("busy_idle", int'(busy), 0);
    endtask

    initial begin
        int n;
        logic bad;

        vecs[0] = '{5, 5, 1};
        for (int i = 1; i <= 4; i++) vecs[i] = '{7, 7, 1};
        vecs[5] = '{7, 8, 2};
        for (int i = 6; i <= 9; i++) vecs[i] = '{13, 13, 1};
        for (int i = 10; i <= 13; i++) vecs[i] = '{1, 1, 1};
        vecs[14] = '{13, 2, 3};
        for (int i = 0; i < 16; i++) rank_cnt[i] = 0;

        // Reset values
        #12 resetb = 1'b1;
        @(negedge clock);
        chk("rst_new_card", int'(new_card), 0);
        chk("rst_valid", int'(card_valid), 0);
        chk("rst_left", int'(cards_left), 52);
        chk("rst_empty", int'(empty), 0);
        chk("rst_busy", int'(busy), 0);

        // Table-driven deals: single, skip exhausted 7, wrap past 13 and 1
        for (int i = 0; i < 15; i++) begin
            deal_at(vecs[i].r, vecs[i].card, vecs[i].lat, 52 - (i + 1));
        end

        // Asynchronous reset in the middle of SEARCH
        deal_req = 1'b1;
        @(posedge clock);
        #2;
        chk("pre_reset_busy", int'(busy), 1);
        resetb = 1'b0;
        #1;
        chk("arst_new_card", int'(new_card), 0);
        chk("arst_valid", int'(card_valid), 0);
        chk("arst_left", int'(cards_left), 52);
        chk("arst_empty", int'(empty), 0);
        chk("arst_busy", int'(busy), 0);
        deal_req = 1'b0;
        @(negedge clock);
        resetb = 1'b1;
        @(negedge clock);
        deal_at(3, 3, 1, 51);

        // Refill one cycle after a request, deal_req still high
        deal_req = 1'b1;
        @(posedge clock);
        #1 refill = 1'b1;
        @(posedge clock);
        #1;
        chk("refill_busy", int'(busy), 0);
        chk("refill_new_card", int'(new_card), 0);
        chk("refill_left", int'(cards_left), 52);
        chk("refill_empty", int'(empty), 0);
        chk("refill_valid", int'(card_valid), 0);
        refill = 1'b0;
        deal_req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("refill_no_pulse", int'(card_valid), 0);

        // Drain the whole shoe with deal_req held high
        drain_mode = 1'b1;
        deal_req = 1'b1;
        n = 0;
        while (drain_cnt < 52 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        chk("drain_count", drain_cnt, 52);
        chk("drain_empty", int'(empty), 1);
        chk("drain_left_zero", int'(cards_left), 0);
        for (int k = 1; k <= 13; k++) chk("drain_rank_count", rank_cnt[k], 4);
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (busy || card_valid) bad = 1'b1;
        end
        chk("empty_ignores_req", int'(bad), 0);
        chk("empty_no_extra_card", drain_cnt, 52);
        deal_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
